mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 2, SHALL set fixed shared-memory read latency in cycles (legal 1..15).
REQ-002 Parameter AW, default 32, SHALL set address width.
REQ-003 clk  input  1  SHALL be the single clock; all state on rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 if_req  input  1  instruction-fetch request; if_addr  input  AW  fetch word address.
REQ-006 if_gnt  output  1  one-cycle grant to fetch port; if_rvalid  output  1  fetch data valid; if_rdata  output  32  fetch data.
REQ-007 d_req  input  1  data-port request; d_we  input  1  1=store, 0=load; d_addr  input  AW  word address; d_wdata  input  32  store data.
REQ-008 d_gnt  output  1  one-cycle grant to data port; d_rvalid  output  1  data completion; d_rdata  output  32  load data.
REQ-009 mem_en  output  1  memory access strobe; mem_we  output  1  write strobe; mem_addr  output  AW; mem_wdata  output  32.
REQ-010 mem_rdata  input  32  memory read data, valid exactly MEM_LAT cycles after the mem_en cycle.
REQ-011 busy  output  1  high whenever state is not IDLE.

Function
REQ-012 FSM states SHALL be IDLE, GRANT, WAIT, RESP; one transaction in flight at most.
REQ-013 IDLE: arbitration on rising edge; if any req high, next state GRANT with winner latched; else stay IDLE.
REQ-014 GRANT (cycle G): winner's gnt=1, mem_en=1, mem_we=d_we (data winner) or 0 (fetch), mem_addr/mem_wdata from latched request registers.
REQ-015 WAIT: held for MEM_LAT-1 cycles via 4-bit down-counter; skipped when MEM_LAT=1.
REQ-016 RESP (cycle G+MEM_LAT): winner's rvalid=1 for one cycle; rdata=mem_rdata for loads/fetches, 0 for stores; next state IDLE.
REQ-017 Request address/data/we SHALL be captured at the arbitration edge; requester changes after that edge SHALL not affect the transaction.
REQ-018 Requester SHALL hold req and payload until gnt; req low at an arbitration edge withdraws it, no grant issued.
REQ-019 Requests arriving while busy SHALL wait; earliest next grant is cycle G+MEM_LAT+2.
REQ-020 gnt and rvalid of the non-winning port SHALL remain 0 throughout a transaction; if_gnt and d_gnt never high together.
REQ-021 Non-RESP cycles: if_rdata and d_rdata SHALL be 0.
REQ-022 Starvation guard: 4-bit counter of consecutive arbitration losses per port; at 8 losses that port SHALL win the next arbitration regardless of policy, counter cleared on its grant.
REQ-023 Single requester SHALL always be granted regardless of policy.

Reset
REQ-024 rst_n low SHALL immediately force IDLE; all outputs 0; latency, loss counters and last-winner register cleared.
REQ-025 Reset mid-transaction SHALL abandon it: no rvalid issued after release; memory write already strobed is not undone.
REQ-026 First arbitration SHALL occur at the first rising edge after rst_n deasserts.

Configuration
REQ-027 Macro ARB_ROUND_ROBIN_EN defined: simultaneous requests SHALL alternate, the port not granted last winning; last-winner resets to fetch (data wins first tie).
REQ-028 Macro ARB_ROUND_ROBIN_EN undefined: data port SHALL win every tie (fixed priority), subject only to REQ-022.

Verification
REQ-029 MEM_LAT=2, if_req=1 if_addr=0x4 at edge 0 -> if_gnt high cycle 1, mem_en=1 mem_addr=0x4 mem_we=0, if_rvalid high cycle 3 with if_rdata=mem_rdata (0xDEADBEEF).
REQ-030 d_req=1 d_we=1 d_addr=0x10 d_wdata=0x55 -> d_gnt with mem_we=1 mem_wdata=0x55, d_rvalid two cycles later with d_rdata=0.
REQ-031 if_req and d_req held high continuously, RR enabled -> grants d,i,d,i...; RR disabled -> d-only until 8th loss, then one fetch grant.
REQ-032 rst_n pulsed low during WAIT -> all outputs 0 immediately, no rvalid after release, new request granted normally.
REQ-033 MEM_LAT=1 -> RESP directly after GRANT; MEM_LAT=15 -> rvalid exactly 15 cycles after gnt.
REQ-034 Request withdrawn and re-addressed while another transaction is busy -> granted payload equals value sampled at arbitration edge.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction fetch / data) arbiter in front of a
// single shared memory with a fixed read latency. One transaction in flight.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   if_req/if_addr               fetch request and word address
//   if_gnt/if_rvalid/if_rdata    fetch grant (1 cycle), completion, read data
//   d_req/d_we/d_addr/d_wdata    data request, 1=store, address, store data
//   d_gnt/d_rvalid/d_rdata       data grant (1 cycle), completion, load data
//   mem_en/mem_we/mem_addr/mem_wdata  shared-memory access strobe and payload
//   mem_rdata                    memory read data, valid MEM_LAT cycles after mem_en
//   busy                         high whenever the FSM is not idle
//
// Configuration
//   ARB_ROUND_ROBIN_EN  defined: ties alternate, the port not granted last wins.
//                       undefined: the data port wins every tie.
//   In both modes a port that has lost 8 consecutive arbitrations wins next.
module mem_arbiter #(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned AW      = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          busy
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] WAIT_INIT = CW'((MEM_LAT >= 2) ? (MEM_LAT - 2) : 0);
  localparam logic [CW-1:0] STARVE    = CW'(8);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(15);
  localparam bit            SKIP_WAIT = (MEM_LAT <= 1);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_WAIT, S_RESP} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   loss_i_q, loss_i_d;
  logic [CW-1:0]   loss_d_q, loss_d_d;
  logic            win_d_q, win_d_d;     // 1: data port owns the transaction
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
`ifdef ARB_ROUND_ROBIN_EN
  logic            last_d_q, last_d_d;   // 1: data port won the last arbitration
`endif
  logic            pick_d;

  logic            if_gnt_q, if_gnt_d, d_gnt_q, d_gnt_d;
  logic            if_rvalid_q, if_rvalid_d, d_rvalid_q, d_rvalid_d;
  logic            mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            busy_q, busy_d;

  // Arbitration winner: starvation guard first, then tie policy
  always_comb begin
    pick_d = d_req;
    if (if_req && d_req) begin
      if (loss_i_q >= STARVE) begin
        pick_d = 1'b0;
      end else if (loss_d_q >= STARVE) begin
        pick_d = 1'b1;
      end else begin
`ifdef ARB_ROUND_ROBIN_EN
        pick_d = ~last_d_q;
`else
        pick_d = 1'b1;
`endif
      end
    end
  end

  // State register and all flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      loss_i_q    <= '0;
      loss_d_q    <= '0;
      win_d_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q    <= 1'b0;
`endif
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      loss_i_q    <= loss_i_d;
      loss_d_q    <= loss_d_d;
      win_d_q     <= win_d_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q    <= last_d_d;
`endif
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  // Next state, request capture and loss bookkeeping
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    loss_i_d = loss_i_q;
    loss_d_d = loss_d_q;
    win_d_d  = win_d_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d_d = last_d_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (if_req || d_req) begin
          state_d = S_GRANT;
          win_d_d = pick_d;
          we_d    = pick_d & d_we;
          addr_d  = pick_d ? d_addr : if_addr;
          wdata_d = pick_d ? d_wdata : '0;
`ifdef ARB_ROUND_ROBIN_EN
          last_d_d = pick_d;
`endif
          // Winner's loss count clears; a requesting loser counts up (saturating)
          if (pick_d) begin
            loss_d_d = '0;
            if (if_req && (loss_i_q != CNT_MAX)) loss_i_d = loss_i_q + CNT_ONE;
          end else begin
            loss_i_d = '0;
            if (d_req && (loss_d_q != CNT_MAX)) loss_d_d = loss_d_q + CNT_ONE;
          end
        end
      end
      S_GRANT: begin
        state_d = SKIP_WAIT ? S_RESP : S_WAIT;
        cnt_d   = WAIT_INIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_RESP;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs decoded from the state being entered
  always_comb begin
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    busy_d      = (state_d != S_IDLE);
    case (state_d)
      S_GRANT: begin
        if_gnt_d    = ~win_d_d;
        d_gnt_d     = win_d_d;
        mem_en_d    = 1'b1;
        mem_we_d    = we_d;
        mem_addr_d  = addr_d;
        mem_wdata_d = wdata_d;
      end
      S_RESP: begin
        if_rvalid_d = ~win_d_d;
        d_rvalid_d  = win_d_d;
      end
      default: ;
    endcase
  end

  assign if_gnt    = if_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

  // Read data is only valid in the response cycle, so it passes straight
  // through, gated by the registered completion strobe (stores return 0).
  assign if_rdata = if_rvalid_q ? mem_rdata : '0;
  assign d_rdata  = (d_rvalid_q && !we_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter plus latency-corner instances.
module tb_mem_arbiter;

  localparam int unsigned LAT = 2;
  localparam int unsigned AW  = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [31:0] mem_rdata = '0;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(LAT), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Latency corner instances: index 0 -> MEM_LAT=1, index 1 -> MEM_LAT=15
  logic        x_rst_n;
  logic        x_if_req[2], x_d_req[2], x_d_we[2];
  logic [31:0] x_if_addr[2], x_d_addr[2], x_d_wdata[2], x_mem_rdata[2];
  logic        x_if_gnt[2], x_if_rvalid[2], x_d_gnt[2], x_d_rvalid[2];
  logic        x_mem_en[2], x_mem_we[2], x_busy[2];
  logic [31:0] x_if_rdata[2], x_d_rdata[2], x_mem_addr[2], x_mem_wdata[2];

  for (genvar g = 0; g < 2; g++) begin : g_lat
    mem_arbiter #(.MEM_LAT((g == 0) ? 1 : 15), .AW(AW)) u_arb (
      .clk(clk), .rst_n(x_rst_n),
      .if_req(x_if_req[g]), .if_addr(x_if_addr[g]), .if_gnt(x_if_gnt[g]),
      .if_rvalid(x_if_rvalid[g]), .if_rdata(x_if_rdata[g]),
      .d_req(x_d_req[g]), .d_we(x_d_we[g]), .d_addr(x_d_addr[g]), .d_wdata(x_d_wdata[g]),
      .d_gnt(x_d_gnt[g]), .d_rvalid(x_d_rvalid[g]), .d_rdata(x_d_rdata[g]),
      .mem_en(x_mem_en[g]), .mem_we(x_mem_we[g]), .mem_addr(x_mem_addr[g]),
      .mem_wdata(x_mem_wdata[g]), .mem_rdata(x_mem_rdata[g]), .busy(x_busy[g])
    );
  end

  typedef struct {
    bit          port_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gnt_cyc;
  } txn_t;

  txn_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  bit   lat_done   = 0;

  task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  // Unwritten memory content; address 4 holds 0xDEADBEEF
  function automatic logic [31:0] init_word(input logic [31:0] a);
    return 32'hDEAD_BEEF ^ ((a ^ 32'd4) * 32'h9E37_79B9);
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'($urandom_range(0, 15));
  endfunction

  // ---------------- reference model + memory environment ----------------
  int          free_e = 0;           // earliest edge at which arbitration may happen
  int          loss[2] = '{0, 0};    // [0] fetch, [1] data consecutive losses
  bit          last_d = 1'b0;
  logic [31:0] ref_mem[logic [31:0]];
  bit          pst_v = 1'b0;
  int          pst_cyc = 0;
  logic [31:0] pst_addr, pst_data;
  logic [31:0] env_mem[logic [31:0]];
  logic [31:0] rd_sched[int];

  always @(posedge clk) begin
    int   k;
    bit   win_d;
    txn_t t;
    k = cyc;
    if (!rst_n) begin
      exp_q.delete();
      rd_sched.delete();
      loss   = '{0, 0};
      last_d = 1'b0;
      pst_v  = 1'b0;
      free_e = k;
    end else begin
      // memory seen by the DUT
      if (mem_en) begin
        if (mem_we) env_mem[mem_addr] = mem_wdata;
        else rd_sched[k + LAT] = env_mem.exists(mem_addr) ? env_mem[mem_addr] : init_word(mem_addr);
      end
      // a store takes effect once its strobe cycle completes
      if (pst_v && pst_cyc == k) begin
        ref_mem[pst_addr] = pst_data;
        pst_v = 1'b0;
      end
      if (k >= free_e && (if_req || d_req)) begin
        if (if_req && d_req) begin
          if (loss[0] >= 8)      win_d = 1'b0;
          else if (loss[1] >= 8) win_d = 1'b1;
          else begin
`ifdef ARB_ROUND_ROBIN_EN
            win_d = !last_d;
`else
            win_d = 1'b1;
`endif
          end
          if (loss[int'(!win_d)] < 15) loss[int'(!win_d)]++;
        end else begin
          win_d = d_req;
        end
        loss[int'(win_d)] = 0;
        last_d    = win_d;
        t.port_d  = win_d;
        t.we      = win_d && d_we;
        t.addr    = win_d ? d_addr : if_addr;
        t.wdata   = d_wdata;
        t.rdata   = t.we ? 32'h0 : (ref_mem.exists(t.addr) ? ref_mem[t.addr] : init_word(t.addr));
        t.gnt_cyc = k + 1;
        exp_q.push_back(t);
        if (t.we) begin
          pst_v = 1'b1; pst_cyc = k + 1; pst_addr = t.addr; pst_data = d_wdata;
        end
        free_e = k + LAT + 2;
      end
    end
    cyc = cyc + 1;
    if (rd_sched.exists(cyc)) begin
      mem_rdata = rd_sched[cyc];
      rd_sched.delete(cyc);
    end else begin
      mem_rdata = $urandom;
    end
  end

  // ---------------- monitor ----------------
  txn_t h;
  always @(negedge clk) begin
    logic        e_busy, e_ig, e_dg, e_en, e_we, e_iv, e_dv;
    logic [31:0] e_addr, e_wd, e_ir, e_dr, a_addr, a_wd;
    logic        a_we;
    string       nm;
    bit          pop;
    {e_busy, e_ig, e_dg, e_en, e_we, e_iv, e_dv} = '0;
    e_addr = '0; e_wd = '0; e_ir = '0; e_dr = '0;
    a_we = mem_we; a_addr = mem_addr; a_wd = mem_wdata;
    pop = 1'b0;
    nm  = "idle";
    if (!rst_n) begin
      nm = "reset";
    end else if (exp_q.size() != 0) begin
      h = exp_q[0];
      if (cyc == h.gnt_cyc) begin
        nm = "grant"; e_busy = 1'b1; e_ig = !h.port_d; e_dg = h.port_d; e_en = 1'b1;
        e_we = h.we; e_addr = h.addr; e_wd = h.wdata;
        if (!h.we) a_wd = e_wd;
      end else if (cyc == h.gnt_cyc + LAT) begin
        nm = "resp"; e_busy = 1'b1; e_iv = !h.port_d; e_dv = h.port_d;
        if (h.port_d) e_dr = h.rdata; else e_ir = h.rdata;
        pop = 1'b1;
      end else if (cyc > h.gnt_cyc && cyc < h.gnt_cyc + LAT) begin
        nm = "wait"; e_busy = 1'b1;
      end
    end
    if (rst_n && !e_en) begin
      a_we = 1'b0; a_addr = '0; a_wd = '0;
    end
    check(nm, {busy, if_gnt, d_gnt, mem_en, a_we, a_addr, a_wd, if_rvalid, if_rdata, d_rvalid, d_rdata},
              {e_busy, e_ig, e_dg, e_en, e_we, e_addr, e_wd, e_iv, e_ir, e_dv, e_dr});
    if (pop) void'(exp_q.pop_front());
  end

  // ---------------- requester behaviour ----------------
  task automatic step(input bit hold);
    if (hold) begin
      if_req = 1'b1; d_req = 1'b1;
      if (if_gnt) if_addr = rand_addr();
      if (d_gnt) begin d_addr = rand_addr(); d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom; end
    end else begin
      if (if_gnt) begin if_req = 1'($urandom_range(0, 1)); if_addr = rand_addr(); end
      else if (if_req) begin if ($urandom_range(0, 19) == 0) if_req = 1'b0; end
      else begin if_addr = rand_addr(); if_req = ($urandom_range(0, 3) == 0); end
      if (d_gnt) begin
        d_req = 1'($urandom_range(0, 1)); d_addr = rand_addr();
        d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom;
      end else if (d_req) begin
        if ($urandom_range(0, 19) == 0) d_req = 1'b0;
      end else begin
        d_addr = rand_addr(); d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom;
        d_req = ($urandom_range(0, 3) == 0);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (3) @(negedge clk);
    // fetch of address 4 presented for the first arbitration edge
    #2 rst_n = 1'b1; if_req = 1'b1; if_addr = 32'h4;
    @(negedge clk);
    if_req = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'h55;
    @(negedge clk);
    d_req = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    // both ports requesting back to back
    repeat (400) begin @(negedge clk); step(1'b1); end
    if_req = 1'b0; d_req = 1'b0;
    // random traffic with reset pulses at arbitrary points
    for (int p = 0; p < 8; p++) begin
      repeat ($urandom_range(150, 300)) begin @(negedge clk); step(1'b0); end
      #2 rst_n = 1'b0;
      #1 check("reset_now", {busy, if_gnt, d_gnt, mem_en, mem_we, mem_addr, mem_wdata,
                             if_rvalid, if_rdata, d_rvalid, d_rdata}, '0);
      repeat (2) begin @(negedge clk); step(1'b0); end
      #2 rst_n = 1'b1;
    end
    repeat (500) begin @(negedge clk); step(1'b0); end
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0;
    repeat (LAT + 6) @(negedge clk);
    check("drain", 160'(exp_q.size()), 160'(0));
    check("lat_done", {159'(0), lat_done}, {159'(0), 1'b1});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // ---------------- latency corners ----------------
  task automatic lat_check(input int k, input int lat, input bit store);
    int n;
    x_mem_rdata[k] = 32'hDEAD_BEEF;
    x_d_we[k] = store;
    if (store) begin x_d_req[k] = 1'b1; x_d_addr[k] = 32'h10; x_d_wdata[k] = 32'h55; end
    else begin x_if_req[k] = 1'b1; x_if_addr[k] = 32'h4; end
    n = 0;
    do begin @(negedge clk); n++; end while (!(x_if_gnt[k] || x_d_gnt[k]) && n < 5);
    check("lat_grant", {x_if_gnt[k], x_d_gnt[k], x_mem_en[k], x_mem_we[k], x_mem_addr[k], 8'(n)},
                       {!store, store, 1'b1, store, (store ? 32'h10 : 32'h4), 8'd1});
    x_if_req[k] = 1'b0; x_d_req[k] = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!(x_if_rvalid[k] || x_d_rvalid[k]) && n < 20);
    check("lat_resp", {x_if_rvalid[k], x_d_rvalid[k], x_if_rdata[k], x_d_rdata[k], 8'(n)},
                      {!store, store, (store ? 32'h0 : 32'hDEAD_BEEF), 32'h0, 8'(lat)});
    repeat (2) @(negedge clk);
  endtask

  initial begin
    x_rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      x_if_req[k] = 1'b0; x_d_req[k] = 1'b0; x_d_we[k] = 1'b0;
      x_if_addr[k] = '0; x_d_addr[k] = '0; x_d_wdata[k] = '0; x_mem_rdata[k] = '0;
    end
    repeat (3) @(negedge clk);
    x_rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 2; s++) lat_check(k, (k == 0) ? 1 : 15, s == 1);
    end
    lat_done = 1'b1;
  end

endmodule
